imem_loader: RTL and testbench
==============================

# imem_loader

Upstream instruction source for the single-cycle CPU core. It loads a program into an internal word-addressed instruction store through a valid/ready stream, and holds the core in reset while loading. Once loading is done it releases the core and serves instruction words combinationally from the core's fetch address. The core consumes the fetched word in the same cycle.

## Interface
- ADDR_WIDTH, 32, fetch address width (byte address)
- DAT_WIDTH, 32, instruction/load word width
- DEPTH_WORDS, 256, instruction store depth in words; power of two, ≥2
- NOP_WORD, 32'h0000_0013, word returned for unloaded/invalid fetches (addi x0,x0,0)

- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_valid_i  in  1  load word present
- load_ready_o  out  1  block accepts a load word this cycle
- load_data_i  in  DAT_WIDTH  program word, in ascending address order from address 0
- load_last_i  in  1  qualifies final word of the program; sampled with valid
- reload_i  in  1  RUN-state request to restart loading
- fetch_addr_i  in  ADDR_WIDTH  core PC (byte address)
- fetch_data_o  out  DAT_WIDTH  instruction word, combinational from fetch_addr_i
- cpu_rst_n_o  out  1  active-low reset to the core; low except in RUN
- word_count_o  out  $clog2(DEPTH_WORDS)+1  number of words loaded
- done_o  out  1  high in RUN
- error_o  out  1  high in ERR (overflow)
- misalign_o  out  1  combinational; fetch_addr_i[1:0] != 0

## Operation
- State machine: LOAD, RUN, ERR. Reset state is LOAD.
- LOAD:
  - load_ready_o=1.
  - On each accepted word (valid&&ready at an edge): mem[wr_ptr] <= load_data_i; wr_ptr and word_count increment.
  - Accepted word with load_last_i=1 → RUN.
  - Accepted word at wr_ptr==DEPTH_WORDS-1 with load_last_i=0 → ERR. The word is still written and counted.
  - Last-word-at-DEPTH_WORDS-1 → RUN, not ERR.
- RUN:
  - load_ready_o=0; load inputs ignored.
  - reload_i=1 at an edge → LOAD, with wr_ptr=0 and word_count=0. Memory contents are not cleared but become unreadable (see fetch rule).
- ERR:
  - load_ready_o=0; cpu_rst_n_o=0; error_o=1.
  - reload_i ignored. Exit only via rst_n.
- Outputs decoded from the registered state only (glitch-free):
  - cpu_rst_n_o=(state==RUN)
  - done_o=(state==RUN)
  - error_o=(state==ERR)
- Fetch rule, index = fetch_addr_i[$clog2(DEPTH_WORDS)+1:2]:
  - fetch_data_o = mem[index] only if fetch_addr_i[1:0]==0, fetch_addr_i upper bits above the index are zero, and index < word_count.
  - Otherwise fetch_data_o = NOP_WORD.
  - Never output X, including after reset with an uninitialised array.
- word_count saturates naturally at DEPTH_WORDS (ERR stops further writes).
- Memory array has no reset; wr_ptr and word_count reset to 0.

## Timing
- Reset values: load_ready_o=1, cpu_rst_n_o=0, done_o=0, error_o=0, word_count_o=0, fetch_data_o=NOP_WORD.
- Asynchronous reset mid-load or mid-run: immediate return to LOAD with cpu_rst_n_o=0 and the counts cleared.
- Load throughput: one word per cycle while valid stays high.
- A written word is fetch-visible from the cycle after its accepting edge.
- cpu_rst_n_o rises in the cycle following the edge that accepts the last word. The core's first fetch (PC=0) sees mem[0] that cycle.
- reload_i: cpu_rst_n_o falls and load_ready_o rises in the cycle after the sampling edge.
- Fetch path: zero latency, purely combinational from fetch_addr_i and registered state/count.
- load_last_i is ignored unless valid&&ready.

## Test plan
- Load 3 words (0x00500093, 0x00A00113, 0x002081B3; last on the 3rd):
  - load_ready_o=1 throughout.
  - Cycle after 3rd accept: cpu_rst_n_o=1, done_o=1, word_count_o=3.
  - fetch 0x0→0x00500093, 0x8→0x002081B3, 0xC→0x00000013.
- Throttled load, valid toggling every other cycle, 4 words:
  - Only valid cycles are written.
  - word_count_o=4; cpu_rst_n_o stays 0 until the last is accepted.
- Overflow with DEPTH_WORDS=4, 5 words and no last:
  - The 4th accept → ERR: error_o=1, load_ready_o=0, cpu_rst_n_o=0, word_count_o=4.
  - The 5th word is not accepted.
  - reload_i has no effect.
  - rst_n recovers to LOAD.
- Exact-fit with DEPTH_WORDS=4, last on the 4th word → RUN, error_o=0.
- Reload and fetch guards:
  - In RUN, pulse reload_i → LOAD, word_count_o=0, and fetch 0x0 returns 0x00000013.
  - Load 1 new word 0x00100073 → RUN; fetch 0x0 returns 0x00100073.
  - Fetch 0x2 → NOP with misalign_o=1.
  - Fetch 0x400 → NOP.
- Async reset asserted mid-load after 2 words:
  - Outputs immediately return to the reset values.
  - A subsequent 1-word load works.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
// Loads a program into a word-addressed instruction store through a
// valid/ready stream. While it loads, it holds the CPU core in reset.
// Once the program is in, it releases the core. From then on it serves
// instruction words combinationally from the core's fetch address.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   load_valid_i    load word present
//   load_ready_o    a load word is accepted this cycle (LOAD only)
//   load_data_i     program word, ascending addresses from 0
//   load_last_i     marks the final program word (only with valid&&ready)
//   reload_i        in RUN: restart loading
//   fetch_addr_i    core PC (byte address)
//   fetch_data_o    instruction word; NOP_WORD for unloaded/invalid fetches
//   cpu_rst_n_o     active-low core reset, high only in RUN
//   word_count_o    number of words loaded
//   done_o          high in RUN
//   error_o         high in ERR (store overflowed without a last word)
//   misalign_o      fetch address not word aligned
//
// state | meaning
// ------+-----------------------------------------------------------
// LOAD  | accepting program words, core held in reset
// RUN   | program loaded, core released, fetches served
// ERR   | overflow without last word; sticky until rst_n

module imem_loader #(
   parameter int unsigned       ADDR_WIDTH  = 32,
   parameter int unsigned       DAT_WIDTH   = 32,
   parameter int unsigned       DEPTH_WORDS = 256,
   parameter logic [DAT_WIDTH-1:0] NOP_WORD = 32'h0000_0013
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           load_valid_i,
   output logic                           load_ready_o,
   input  logic [DAT_WIDTH-1:0]           load_data_i,
   input  logic                           load_last_i,
   input  logic                           reload_i,
   input  logic [ADDR_WIDTH-1:0]          fetch_addr_i,
   output logic [DAT_WIDTH-1:0]           fetch_data_o,
   output logic                           cpu_rst_n_o,
   output logic [$clog2(DEPTH_WORDS):0]   word_count_o,
   output logic                           done_o,
   output logic                           error_o,
   output logic                           misalign_o
);

   localparam int unsigned IW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      RUN  = 2'd1,
      ERR  = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [IW-1:0]        wr_ptr;
   logic [IW:0]          word_count;
   logic [DAT_WIDTH-1:0] mem [DEPTH_WORDS];
   logic                 accept;

   // load_ready_o is a registered decode of state, so accept is glitch-free.
   assign accept = load_ready_o && load_valid_i;

   always_comb begin
      state_nxt = state;
      case (state)
         LOAD: begin
            if (accept) begin
               if (load_last_i)
                  state_nxt = RUN;
               else if (wr_ptr == IW'(DEPTH_WORDS - 1))
                  state_nxt = ERR;
            end
         end
         RUN: begin
            if (reload_i)
               state_nxt = LOAD;
         end
         ERR:     state_nxt = ERR;
         default: state_nxt = LOAD;
      endcase
   end

   // The outputs are registered from the next state. They therefore always
   // equal a decode of the current state, with no combinational path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= LOAD;
         wr_ptr       <= '0;
         word_count   <= '0;
         load_ready_o <= 1'b1;
         cpu_rst_n_o  <= 1'b0;
         done_o       <= 1'b0;
         error_o      <= 1'b0;
      end else begin
         state        <= state_nxt;
         load_ready_o <= (state_nxt == LOAD);
         cpu_rst_n_o  <= (state_nxt == RUN);
         done_o       <= (state_nxt == RUN);
         error_o      <= (state_nxt == ERR);
         if (accept) begin
            // wr_ptr wraps at overflow, but ERR blocks any further write.
            wr_ptr     <= wr_ptr + 1'b1;
            word_count <= word_count + 1'b1;
         end else if (state == RUN && reload_i) begin
            wr_ptr     <= '0;
            word_count <= '0;
         end
      end
   end

   // Storage has no reset. Stale or unwritten entries are masked by word_count.
   always_ff @(posedge clk) begin
      if (accept)
         mem[wr_ptr] <= load_data_i;
   end

   logic [IW-1:0] fetch_index;
   logic          upper_zero;
   logic          fetch_ok;

   assign fetch_index = fetch_addr_i[IW+1:2];
   assign upper_zero  = ((fetch_addr_i >> (IW + 2)) == '0);
   assign misalign_o  = (fetch_addr_i[1:0] != 2'b00);
   assign fetch_ok    = !misalign_o && upper_zero && ({1'b0, fetch_index} < word_count);

   // Only written entries are ever selected, so fetch_data_o is never X.
   assign fetch_data_o = fetch_ok ? mem[fetch_index] : NOP_WORD;
   assign word_count_o = word_count;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_valid_i;
   logic        load_ready_o;
   logic [31:0] load_data_i;
   logic        load_last_i;
   logic        reload_i;
   logic [31:0] fetch_addr_i;
   logic [31:0] fetch_data_o;
   logic        cpu_rst_n_o;
   logic [2:0]  word_count_o;
   logic        done_o;
   logic        error_o;
   logic        misalign_o;

   imem_loader #(
      .ADDR_WIDTH (32),
      .DAT_WIDTH  (32),
      .DEPTH_WORDS(DEPTH),
      .NOP_WORD   (NOP)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_valid_i (load_valid_i),
      .load_ready_o (load_ready_o),
      .load_data_i  (load_data_i),
      .load_last_i  (load_last_i),
      .reload_i     (reload_i),
      .fetch_addr_i (fetch_addr_i),
      .fetch_data_o (fetch_data_o),
      .cpu_rst_n_o  (cpu_rst_n_o),
      .word_count_o (word_count_o),
      .done_o       (done_o),
      .error_o      (error_o),
      .misalign_o   (misalign_o)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } sb_t;

   sb_t sb[$];

   typedef struct {
      logic [31:0] addr;
      logic [31:0] exp_data;
      logic        exp_mis;
   } fvec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_chk(input string name, input logic [31:0] addr,
                            input logic [31:0] exp, input logic exp_mis);
      fetch_addr_i = addr;
      #1;
      chk({name, "_data"}, fetch_data_o, exp);
      chk({name, "_mis"}, {31'b0, misalign_o}, {31'b0, exp_mis});
   endtask

   // Pops every word pushed by the load tasks and fetches it back.
   task automatic drain_sb(input string name);
      sb_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         fetch_chk(name, e.addr, e.data, 1'b0);
      end
   endtask

   task automatic check_reset_vals(input string name);
      chk({name, "_ready"}, {31'b0, load_ready_o}, 32'd1);
      chk({name, "_cpurst"}, {31'b0, cpu_rst_n_o}, 32'd0);
      chk({name, "_done"}, {31'b0, done_o}, 32'd0);
      chk({name, "_err"}, {31'b0, error_o}, 32'd0);
      chk({name, "_cnt"}, {29'b0, word_count_o}, 32'd0);
      fetch_chk({name, "_f0"}, 32'h0, NOP, 1'b0);
   endtask

   task automatic do_reload();
      reload_i = 1'b1;
      tick();
      reload_i = 1'b0;
   endtask

   initial begin
      fvec_t fv[8];
      logic [31:0] prog3[3];
      logic [31:0] prog4[4];
      int          pushed;

      prog3 = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};
      prog4 = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
      fv = '{
         '{32'h0000_0000, 32'h0050_0093, 1'b0},
         '{32'h0000_0004, 32'h00A0_0113, 1'b0},
         '{32'h0000_0008, 32'h0020_81B3, 1'b0},
         '{32'h0000_000C, NOP,           1'b0},
         '{32'h0000_0002, NOP,           1'b1},
         '{32'h0000_0010, NOP,           1'b0},
         '{32'h0000_0400, NOP,           1'b0},
         '{32'h8000_0000, NOP,           1'b0}
      };

      rst_n        = 1'b0;
      load_valid_i = 1'b0;
      load_data_i  = '0;
      load_last_i  = 1'b0;
      reload_i     = 1'b0;
      fetch_addr_i = '0;
      #12;
      check_reset_vals("reset");
      rst_n = 1'b1;
      tick();

      // Three-word load, last on the third
      for (int i = 0; i < 3; i++) begin
         load_valid_i = 1'b1;
         load_data_i  = prog3[i];
         load_last_i  = (i == 2);
         chk("l3_ready", {31'b0, load_ready_o}, 32'd1);
         chk("l3_cpurst_low", {31'b0, cpu_rst_n_o}, 32'd0);
         sb.push_back('{32'(i * 4), prog3[i]});
         tick();
      end
      load_valid_i = 1'b0;
      load_last_i  = 1'b0;
      chk("l3_cpurst", {31'b0, cpu_rst_n_o}, 32'd1);
      chk("l3_done", {31'b0, done_o}, 32'd1);
      chk("l3_cnt", {29'b0, word_count_o}, 32'd3);
      drain_sb("l3_sb");
      for (int i = 0; i < 8; i++)
         fetch_chk($sformatf("l3_vec%0d", i), fv[i].addr, fv[i].exp_data, fv[i].exp_mis);

      // Load inputs are ignored in RUN
      load_valid_i = 1'b1;
      load_data_i  = 32'hDEAD_BEEF;
      tick();
      load_valid_i = 1'b0;
      chk("run_ignore_cnt", {29'b0, word_count_o}, 32'd3);
      chk("run_ready", {31'b0, load_ready_o}, 32'd0);

      // Reload, then a throttled four-word load that exactly fits
      do_reload();
      chk("rl_ready", {31'b0, load_ready_o}, 32'd1);
      chk("rl_cpurst", {31'b0, cpu_rst_n_o}, 32'd0);
      chk("rl_cnt", {29'b0, word_count_o}, 32'd0);
      fetch_chk("rl_f0", 32'h0, NOP, 1'b0);
      pushed = 0;
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) begin
            load_valid_i = 1'b1;
            load_data_i  = prog4[k/2];
            load_last_i  = (k == 6);
            sb.push_back('{32'((k/2) * 4), prog4[k/2]});
            pushed++;
         end else begin
            // The junk word and the stray last flag must not be taken.
            load_valid_i = 1'b0;
            load_data_i  = 32'hBAD0_0000 | 32'(k);
            load_last_i  = 1'b1;
         end
         tick();
         chk("thr_cnt", {29'b0, word_count_o}, 32'(pushed));
         chk("thr_cpurst", {31'b0, cpu_rst_n_o}, (pushed == 4) ? 32'd1 : 32'd0);
      end
      load_valid_i = 1'b0;
      load_last_i  = 1'b0;
      chk("fit_err", {31'b0, error_o}, 32'd0);
      chk("fit_done", {31'b0, done_o}, 32'd1);
      drain_sb("thr_sb");

      // Reload and a single new word; the stale entries must be hidden
      do_reload();
      fetch_chk("rl2_f0", 32'h0, NOP, 1'b0);
      load_valid_i = 1'b1;
      load_data_i  = 32'h0010_0073;
      load_last_i  = 1'b1;
      tick();
      load_valid_i = 1'b0;
      load_last_i  = 1'b0;
      chk("one_done", {31'b0, done_o}, 32'd1);
      fetch_chk("one_f0", 32'h0, 32'h0010_0073, 1'b0);
      fetch_chk("one_stale", 32'h4, NOP, 1'b0);
      fetch_chk("one_mis", 32'h2, NOP, 1'b1);
      fetch_chk("one_hi", 32'h400, NOP, 1'b0);

      // Overflow: four words without last, then a fifth
      do_reload();
      for (int i = 0; i < 4; i++) begin
         load_valid_i = 1'b1;
         load_data_i  = 32'hA000_0000 | 32'(i);
         load_last_i  = 1'b0;
         tick();
      end
      chk("ovf_err", {31'b0, error_o}, 32'd1);
      chk("ovf_ready", {31'b0, load_ready_o}, 32'd0);
      chk("ovf_cpurst", {31'b0, cpu_rst_n_o}, 32'd0);
      chk("ovf_done", {31'b0, done_o}, 32'd0);
      chk("ovf_cnt", {29'b0, word_count_o}, 32'd4);
      load_data_i = 32'hA000_0004;
      tick();
      load_valid_i = 1'b0;
      chk("ovf5_cnt", {29'b0, word_count_o}, 32'd4);
      do_reload();
      chk("ovf_rl_err", {31'b0, error_o}, 32'd1);
      chk("ovf_rl_ready", {31'b0, load_ready_o}, 32'd0);
      rst_n = 1'b0;
      #1;
      check_reset_vals("ovf_rst");
      rst_n = 1'b1;
      tick();

      // Async reset in the middle of a load
      for (int i = 0; i < 2; i++) begin
         load_valid_i = 1'b1;
         load_data_i  = 32'hC000_0000 | 32'(i);
         load_last_i  = 1'b0;
         tick();
      end
      chk("mid_cnt", {29'b0, word_count_o}, 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("mid_rst");
      rst_n = 1'b1;
      load_valid_i = 1'b1;
      load_data_i  = 32'h0000_0093;
      load_last_i  = 1'b1;
      tick();
      load_valid_i = 1'b0;
      load_last_i  = 1'b0;
      chk("mid_done", {31'b0, done_o}, 32'd1);
      chk("mid_cnt1", {29'b0, word_count_o}, 32'd1);
      fetch_chk("mid_f0", 32'h0, 32'h0000_0093, 1'b0);
      fetch_chk("mid_f4", 32'h4, NOP, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
